// File: rtl/sparc_sr_pkg.sv
// Shared definitions for the state-register write side: PSR field positions,
// write-target encodings, reset values and the mod-NWINDOWS CWP helpers.
package sparc_sr_pkg;

  localparam int PSR_ICC_LSB = 20;
  localparam int PSR_EC      = 13;
  localparam int PSR_EF      = 12;
  localparam int PSR_PIL_LSB = 8;
  localparam int PSR_S       = 7;
  localparam int PSR_PS      = 6;
  localparam int PSR_ET      = 5;
  localparam int PSR_CWP_LSB = 0;

  // impl, ver and the reserved field [19:14] always read back as zero
  localparam logic [31:0] PSR_WRITE_MASK = 32'h00F0_3FFF;

  localparam logic [31:0] PSR_RESET = 32'h0000_0080;
  localparam logic [31:0] TBR_RESET = 32'h0000_0000;
  localparam logic [31:0] WIM_RESET = 32'h0000_0000;

  localparam int DEFAULT_NWINDOWS = 8;

  typedef enum logic [1:0] {
    SR_SEL_PSR  = 2'b00,
    SR_SEL_TBR  = 2'b01,
    SR_SEL_WIM  = 2'b10,
    SR_SEL_NONE = 2'b11
  } sr_sel_e;

  typedef struct packed {
    logic        valid;
    sr_sel_e     sel;
    logic [31:0] data;
  } sr_wr_entry_t;

  function automatic logic [4:0] cwp_dec(input logic [4:0] cwp, input logic [4:0] last);
    return (cwp == 5'd0) ? last : cwp - 5'd1;
  endfunction

  function automatic logic [4:0] cwp_inc(input logic [4:0] cwp, input logic [4:0] last);
    return (cwp == last) ? 5'd0 : cwp + 5'd1;
  endfunction

endpackage

// File: rtl/sr_write_delay_pipe.sv
// Fixed-depth shift register carrying delayed state-register writes; the
// oldest stage is presented as the commit candidate for the current edge.
module sr_write_delay_pipe
  import sparc_sr_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  sr_sel_e      push_sel,
  input  logic [31:0]  push_data,
  input  logic         flush,
  output sr_wr_entry_t head,
  output logic         any_valid
);

  sr_wr_entry_t stage_q [DEPTH];
  sr_wr_entry_t stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = '0;
    end
    if (!flush) begin
      stage_d[0] = '{valid: push, sel: push_sel, data: push_data};
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign head = stage_q[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

endmodule

// File: rtl/state_register_write_unit.sv
// Owns PSR/TBR/WIM: delayed WRPSR/WRTBR/WRWIM commits, then trap/RETT/window/icc
// updates overlaid on the committed value, plus registered fault pulses.
module state_register_write_unit
  import sparc_sr_pkg::*;
#(
  parameter int NWINDOWS    = DEFAULT_NWINDOWS,
  parameter int WRITE_DELAY = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        SR_Write,
  input  logic [1:0]  SR_Select,
  input  logic [31:0] Write_Data,
  input  logic        ICC_Write,
  input  logic [3:0]  ICC_In,
  input  logic        Save,
  input  logic        Restore,
  input  logic        Trap_Enter,
  input  logic [7:0]  Trap_Type,
  input  logic        Rett,
  output logic [31:0] PSR,
  output logic [31:0] TBR,
  output logic [31:0] WIM,
  output logic        Write_Pending,
  output logic        Privileged_Fault,
  output logic        Illegal_Write,
  output logic        Window_Overflow,
  output logic        Window_Underflow
);

  localparam logic [4:0]  LAST_CWP = 5'(NWINDOWS - 1);
  localparam logic [5:0]  NWIN     = 6'(NWINDOWS);
  localparam logic [31:0] WIM_MASK = (NWINDOWS >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << NWINDOWS) - 32'd1);

  logic [31:0]  psr_q, psr_d, tbr_q, tbr_d, wim_q, wim_d;
  logic         priv_fault_q, priv_fault_d, illegal_q, illegal_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]  psr_c, tbr_c, wim_c;
  logic [4:0]   cwp_c, cwp_new;
  logic         issue, push, any_valid;
  sr_sel_e      wr_sel;
  sr_wr_entry_t head;

  assign wr_sel = sr_sel_e'(SR_Select);

  // Privilege and CWP legality are judged against committed state only
  always_comb begin
    issue        = SR_Write && (wr_sel != SR_SEL_NONE) && !Trap_Enter;
    priv_fault_d = issue && !psr_q[PSR_S];
    illegal_d    = issue && psr_q[PSR_S] && (wr_sel == SR_SEL_PSR) &&
                   ({1'b0, Write_Data[4:0]} >= NWIN);
    push         = issue && !priv_fault_d && !illegal_d;
  end

  sr_write_delay_pipe #(
    .DEPTH(WRITE_DELAY)
  ) u_pipe (
    .clk      (Clk),
    .rst      (Reset),
    .push     (push),
    .push_sel (wr_sel),
    .push_data(Write_Data),
    .flush    (Trap_Enter),
    .head     (head),
    .any_valid(any_valid)
  );

  always_comb begin
    psr_c = psr_q;
    tbr_c = tbr_q;
    wim_c = wim_q;
    if (head.valid) begin
      case (head.sel)
        SR_SEL_PSR: psr_c = head.data & PSR_WRITE_MASK;
        SR_SEL_TBR: tbr_c = {head.data[31:12], tbr_q[11:4], 4'h0};
        SR_SEL_WIM: wim_c = head.data & WIM_MASK;
        default:    ;
      endcase
    end
  end

  // Trap beats everything; RETT beats SAVE/RESTORE; SAVE beats RESTORE
  always_comb begin
    psr_d   = psr_c;
    tbr_d   = tbr_c;
    wim_d   = wim_c;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    cwp_c   = psr_c[PSR_CWP_LSB +: 5];
    cwp_new = cwp_c;
    if (Trap_Enter) begin
      psr_d[PSR_CWP_LSB +: 5] = cwp_dec(cwp_c, LAST_CWP);
      psr_d[PSR_PS]           = psr_c[PSR_S];
      psr_d[PSR_S]            = 1'b1;
      psr_d[PSR_ET]           = 1'b0;
      tbr_d[11:4]             = Trap_Type;
    end else begin
      if (ICC_Write) begin
        psr_d[PSR_ICC_LSB +: 4] = ICC_In;
      end
      if (Rett) begin
        psr_d[PSR_CWP_LSB +: 5] = cwp_inc(cwp_c, LAST_CWP);
        psr_d[PSR_S]            = psr_c[PSR_PS];
        psr_d[PSR_ET]           = 1'b1;
      end else if (Save) begin
        cwp_new = cwp_dec(cwp_c, LAST_CWP);
        if (wim_c[cwp_new]) ovf_d = 1'b1;
        else psr_d[PSR_CWP_LSB +: 5] = cwp_new;
      end else if (Restore) begin
        cwp_new = cwp_inc(cwp_c, LAST_CWP);
        if (wim_c[cwp_new]) unf_d = 1'b1;
        else psr_d[PSR_CWP_LSB +: 5] = cwp_new;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      psr_q        <= PSR_RESET;
      tbr_q        <= TBR_RESET;
      wim_q        <= WIM_RESET;
      priv_fault_q <= 1'b0;
      illegal_q    <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      psr_q        <= psr_d;
      tbr_q        <= tbr_d;
      wim_q        <= wim_d;
      priv_fault_q <= priv_fault_d;
      illegal_q    <= illegal_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign PSR              = psr_q;
  assign TBR              = tbr_q;
  assign WIM              = wim_q;
  assign Write_Pending    = any_valid;
  assign Privileged_Fault = priv_fault_q;
  assign Illegal_Write    = illegal_q;
  assign Window_Overflow  = ovf_q;
  assign Window_Underflow = unf_q;

endmodule

// File: tb/tb_state_register_write_unit.sv
// Directed bench for state_register_write_unit (NWINDOWS=8, WRITE_DELAY=3);
// expected values are hand-computed from the architectural behaviour.
module tb_state_register_write_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        SR_Write = 1'b0;
  logic [1:0]  SR_Select = 2'b11;
  logic [31:0] Write_Data = '0;
  logic        ICC_Write = 1'b0;
  logic [3:0]  ICC_In = '0;
  logic        Save = 1'b0;
  logic        Restore = 1'b0;
  logic        Trap_Enter = 1'b0;
  logic [7:0]  Trap_Type = '0;
  logic        Rett = 1'b0;
  logic [31:0] PSR, TBR, WIM;
  logic        Write_Pending, Privileged_Fault, Illegal_Write;
  logic        Window_Overflow, Window_Underflow;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [1:0] SEL_PSR = 2'b00;
  localparam logic [1:0] SEL_TBR = 2'b01;
  localparam logic [1:0] SEL_WIM = 2'b10;

  state_register_write_unit #(
    .NWINDOWS   (8),
    .WRITE_DELAY(3)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .SR_Write        (SR_Write),
    .SR_Select       (SR_Select),
    .Write_Data      (Write_Data),
    .ICC_Write       (ICC_Write),
    .ICC_In          (ICC_In),
    .Save            (Save),
    .Restore         (Restore),
    .Trap_Enter      (Trap_Enter),
    .Trap_Type       (Trap_Type),
    .Rett            (Rett),
    .PSR             (PSR),
    .TBR             (TBR),
    .WIM             (WIM),
    .Write_Pending   (Write_Pending),
    .Privileged_Fault(Privileged_Fault),
    .Illegal_Write   (Illegal_Write),
    .Window_Overflow (Window_Overflow),
    .Window_Underflow(Window_Underflow)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives whatever strobes are set across one rising edge, then clears them
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
    SR_Write   = 1'b0;
    SR_Select  = 2'b11;
    Write_Data = '0;
    ICC_Write  = 1'b0;
    ICC_In     = '0;
    Save       = 1'b0;
    Restore    = 1'b0;
    Trap_Enter = 1'b0;
    Trap_Type  = '0;
    Rett       = 1'b0;
  endtask

  task automatic issueWrite(input logic [1:0] sel, input logic [31:0] data);
    SR_Write   = 1'b1;
    SR_Select  = sel;
    Write_Data = data;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus();
  endtask

  initial begin
    $display("[TB] starting state_register_write_unit directed test");
    #12;
    checkOutput("reset_psr", PSR, 32'h0000_0080);
    checkOutput("reset_tbr", TBR, 32'h0);
    checkOutput("reset_wim", WIM, 32'h0);
    checkOutput("reset_pending", 32'(Write_Pending), 32'h0);
    checkOutput("reset_pulses", {28'h0, Privileged_Fault, Illegal_Write,
                                 Window_Overflow, Window_Underflow}, 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Delayed PSR write: invisible for edges 1..3, visible after edge 4
    issueWrite(SEL_PSR, 32'h0000_0F83);
    checkOutput("psr_delay_e1", PSR, 32'h0000_0080);
    checkOutput("pending_e1", 32'(Write_Pending), 32'h1);
    idleCycles(1);
    checkOutput("psr_delay_e2", PSR, 32'h0000_0080);
    checkOutput("pending_e2", 32'(Write_Pending), 32'h1);
    idleCycles(1);
    checkOutput("psr_delay_e3", PSR, 32'h0000_0080);
    checkOutput("pending_e3", 32'(Write_Pending), 32'h1);
    idleCycles(1);
    checkOutput("psr_commit_e4", PSR, 32'h0000_0F83);
    checkOutput("pending_e4", 32'(Write_Pending), 32'h0);

    // WIM write masked to NWINDOWS bits, then PSR with CWP=0
    issueWrite(SEL_WIM, 32'hFFFF_FF80);
    issueWrite(SEL_PSR, 32'h0000_0F80);
    idleCycles(1);
    checkOutput("wim_not_yet", WIM, 32'h0);
    idleCycles(1);
    checkOutput("wim_masked", WIM, 32'h0000_0080);
    checkOutput("psr_not_yet", PSR, 32'h0000_0F83);
    checkOutput("pending_second", 32'(Write_Pending), 32'h1);
    idleCycles(1);
    checkOutput("psr_cwp0", PSR, 32'h0000_0F80);

    Save = 1'b1;
    applyStimulus();
    checkOutput("save_ovf_pulse", 32'(Window_Overflow), 32'h1);
    checkOutput("save_ovf_cwp", PSR, 32'h0000_0F80);
    idleCycles(1);
    checkOutput("save_ovf_clear", 32'(Window_Overflow), 32'h0);

    // Back-to-back writes to WIM commit in order, last one wins
    issueWrite(SEL_WIM, 32'h0000_0003);
    issueWrite(SEL_WIM, 32'h0000_0000);
    idleCycles(2);
    checkOutput("wim_first", WIM, 32'h0000_0003);
    idleCycles(1);
    checkOutput("wim_last_wins", WIM, 32'h0);

    Save = 1'b1;
    applyStimulus();
    checkOutput("save_wrap", PSR, 32'h0000_0F87);
    checkOutput("save_no_ovf", 32'(Window_Overflow), 32'h0);

    Restore = 1'b1;
    applyStimulus();
    checkOutput("restore_wrap", PSR, 32'h0000_0F80);
    checkOutput("restore_no_unf", 32'(Window_Underflow), 32'h0);

    issueWrite(SEL_WIM, 32'h0000_0002);
    idleCycles(3);
    Restore = 1'b1;
    applyStimulus();
    checkOutput("restore_unf_pulse", 32'(Window_Underflow), 32'h1);
    checkOutput("restore_unf_cwp", PSR, 32'h0000_0F80);

    // Set CWP=3,S=1,PS=0,ET=1 and a TBR base, then trap over a pending WIM write
    issueWrite(SEL_PSR, 32'h0000_0FA3);
    issueWrite(SEL_TBR, 32'h1234_5678);
    idleCycles(3);
    checkOutput("psr_pre_trap", PSR, 32'h0000_0FA3);
    checkOutput("tbr_masked", TBR, 32'h1234_5000);
    issueWrite(SEL_WIM, 32'h0000_0011);
    Trap_Enter = 1'b1;
    Trap_Type  = 8'h05;
    ICC_Write  = 1'b1;
    ICC_In     = 4'hF;
    Save       = 1'b1;
    applyStimulus();
    checkOutput("trap_psr", PSR, 32'h0000_0FC2);
    checkOutput("trap_tbr", TBR, 32'h1234_5050);
    checkOutput("trap_pending", 32'(Write_Pending), 32'h0);
    checkOutput("trap_no_ovf", 32'(Window_Overflow), 32'h0);
    idleCycles(3);
    checkOutput("trap_wim_kept", WIM, 32'h0000_0002);

    // RETT with PS=0 drops to user mode; icc update coexists with RETT
    issueWrite(SEL_PSR, 32'h0000_0F82);
    idleCycles(3);
    Rett      = 1'b1;
    ICC_Write = 1'b1;
    ICC_In    = 4'hA;
    applyStimulus();
    checkOutput("rett_psr", PSR, 32'h00A0_0F23);

    issueWrite(SEL_TBR, 32'hFFFF_F000);
    checkOutput("priv_fault_pulse", 32'(Privileged_Fault), 32'h1);
    checkOutput("priv_no_pending", 32'(Write_Pending), 32'h0);
    idleCycles(1);
    checkOutput("priv_fault_clear", 32'(Privileged_Fault), 32'h0);
    idleCycles(3);
    checkOutput("priv_tbr_kept", TBR, 32'h1234_5050);

    Trap_Enter = 1'b1;
    Trap_Type  = 8'h80;
    applyStimulus();
    checkOutput("trap2_psr", PSR, 32'h00A0_0F82);
    checkOutput("trap2_tbr", TBR, 32'h1234_5800);

    issueWrite(SEL_PSR, 32'h0000_0F89);
    checkOutput("illegal_pulse", 32'(Illegal_Write), 32'h1);
    checkOutput("illegal_no_pending", 32'(Write_Pending), 32'h0);
    idleCycles(3);
    checkOutput("illegal_psr_kept", PSR, 32'h00A0_0F82);
    checkOutput("illegal_clear", 32'(Illegal_Write), 32'h0);

    // Asynchronous reset with two writes in flight
    issueWrite(SEL_PSR, 32'h0000_0F85);
    issueWrite(SEL_TBR, 32'hABCD_E000);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("async_psr", PSR, 32'h0000_0080);
    checkOutput("async_tbr", TBR, 32'h0);
    checkOutput("async_wim", WIM, 32'h0);
    checkOutput("async_pending", 32'(Write_Pending), 32'h0);
    idleCycles(1);
    Reset = 1'b0;
    idleCycles(4);
    checkOutput("post_reset_psr", PSR, 32'h0000_0080);
    checkOutput("post_reset_tbr", TBR, 32'h0);

    Save    = 1'b1;
    Restore = 1'b1;
    applyStimulus();
    checkOutput("save_beats_restore", PSR, 32'h0000_0087);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
